// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter family.
package arb_pkg;

   localparam int MAX_CLIENTS = 32;
   localparam int MAX_IDX_W   = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   function automatic logic [MAX_CLIENTS-1:0] onehot_from_idx(input logic [MAX_IDX_W-1:0] idx);
      logic [MAX_CLIENTS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker: searches i_ptr+1 upward with wrap,
// so i_ptr itself is considered last.
module arb_rr_pick #(
   parameter  int CLIENTS = 16,
   localparam int IDX_W   = $clog2(CLIENTS)
) (
   input  logic [CLIENTS-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_vld,
   output logic [CLIENTS-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx
);

   logic [IDX_W-1:0] w_cand;

   // Walk from farthest to nearest candidate so the nearest requester is the last write.
   always_comb begin
      o_vld    = 1'b0;
      o_onehot = '0;
      o_idx    = '0;
      w_cand   = '0;
      for (int k = CLIENTS - 1; k >= 0; k--) begin
         w_cand = IDX_W'((int'(i_ptr) + 1 + k) % CLIENTS);
         if (i_req[w_cand]) begin
            o_vld            = 1'b1;
            o_idx            = w_cand;
            o_onehot         = '0;
            o_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_wrr_locked.sv
// Weighted round-robin arbiter for a multi-cycle resource: the grant is locked
// until ack, and each tenure allows weight+1 transactions before rotating.
module arb_wrr_locked
   import arb_pkg::*;
#(
   parameter  int CLIENTS  = 16,
   parameter  int WEIGHT_W = 4,
   localparam int IDX_W    = $clog2(CLIENTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CLIENTS-1:0]          req,
   input  logic [CLIENTS*WEIGHT_W-1:0] weight,
   input  logic                        ack,
   output logic [CLIENTS-1:0]          gnt,
   output logic [IDX_W-1:0]            gnt_id,
   output logic                        gnt_vld,
   output logic                        dbg_state
);

   arb_state_t          r_state;
   logic [IDX_W-1:0]    r_ptr;
   logic [WEIGHT_W-1:0] r_credit;
   logic [CLIENTS-1:0]  r_gnt;
   logic [IDX_W-1:0]    r_gnt_id;
   logic                r_gnt_vld;

   logic                w_pick_vld;
   logic [CLIENTS-1:0]  w_pick_onehot;
   logic [IDX_W-1:0]    w_pick_idx;
   logic [WEIGHT_W-1:0] w_pick_weight;
   logic                w_owner_req;
   logic                w_credit_left;
   logic                w_release;
   logic                w_arbitrate;

   arb_rr_pick #(.CLIENTS(CLIENTS)) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_vld    (w_pick_vld),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx)
   );

   // r_gnt_id doubles as the owner register; it is only meaningful in OWNED.
   assign w_owner_req   = req[r_gnt_id];
   assign w_credit_left = (r_credit != '0);
   assign w_release     = (r_state == OWNED) && (!w_owner_req || (ack && !w_credit_left));
   assign w_arbitrate   = (r_state == IDLE) || w_release;
   assign w_pick_weight = weight[w_pick_idx*WEIGHT_W +: WEIGHT_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= IDX_W'(CLIENTS - 1);
         r_credit  <= '0;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_gnt_vld <= 1'b0;
      end else if (w_arbitrate) begin
         if (w_pick_vld) begin
            r_state   <= OWNED;
            r_ptr     <= w_pick_idx;
            r_credit  <= w_pick_weight;
            r_gnt     <= w_pick_onehot;
            r_gnt_id  <= w_pick_idx;
            r_gnt_vld <= 1'b1;
         end else begin
            r_state   <= IDLE;
            r_credit  <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_gnt_vld <= 1'b0;
         end
      end else if (ack && w_credit_left) begin
         r_credit <= r_credit - WEIGHT_W'(1);
      end
   end

   assign gnt       = r_gnt;
   assign gnt_id    = r_gnt_id;
   assign gnt_vld   = r_gnt_vld;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_arb_wrr_locked.sv
// Directed bench for arb_wrr_locked with 4 clients: the driver queues the
// grant expected after each cycle, a negedge monitor pops and compares.
module tb_arb_wrr_locked;

   localparam int CLIENTS  = 4;
   localparam int WEIGHT_W = 4;
   localparam int W        = 7;   // {gnt_vld, gnt[3:0], gnt_id[1:0]}

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] weight = '0;
   logic        ack = 1'b0;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        gnt_vld;
   logic        dbg_state;

   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];
   int           cyc_cnt = 0;
   int           n_checks = 0;
   int           n_fail = 0;

   arb_wrr_locked #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .weight    (weight),
      .ack       (ack),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_vld   (gnt_vld),
      .dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // id < 0 means idle (all outputs zero)
   function automatic logic [W-1:0] ex(input int id);
      logic [3:0] oh;
      logic [1:0] idx;
      oh  = '0;
      idx = '0;
      if (id >= 0) begin
         oh[id] = 1'b1;
         idx    = id[1:0];
      end
      return (id < 0) ? '0 : {1'b1, oh, idx};
   endfunction

   // driver: apply req/ack for one cycle and queue the grant visible afterwards
   task automatic step(input logic [3:0] r, input logic a, input int exp_id);
      req = r;
      ack = a;
      exp_q.push_back(ex(exp_id));
      exp_cyc_q.push_back(cyc_cnt + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string name, input int exp_id);
      n_checks++;
      if ({gnt_vld, gnt, gnt_id} !== ex(exp_id)) begin
         n_fail++;
         $display("FAIL %s: got vld=%b gnt=%b id=%0d, want %b", name, gnt_vld, gnt, gnt_id, ex(exp_id));
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [W-1:0] e;
      int           c;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc_cnt) begin
         c = exp_cyc_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if ({gnt_vld, gnt, gnt_id} !== e || c != cyc_cnt) begin
            n_fail++;
            $display("FAIL grant@cyc%0d: got vld=%b gnt=%b id=%0d, want %b (queued for cyc%0d)",
                     cyc_cnt, gnt_vld, gnt, gnt_id, e, c);
         end
      end
   end

   initial begin
      // reset and idle
      #1 rst = 1'b1;
      #1 check_now("async_reset", -1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step(4'b0000, 1'(i % 2), -1);

      // fair rotation, all weights 0
      weight = 16'h0000;
      step(4'b1111, 1'b0, 0);
      step(4'b1111, 1'b1, 1);
      step(4'b1111, 1'b1, 2);
      step(4'b1111, 1'b1, 3);
      step(4'b1111, 1'b1, 0);
      step(4'b1111, 1'b1, 1);
      step(4'b0000, 1'b1, -1);

      // weighting: client 1 weight 2 (ptr=1, so client 0 wins first)
      weight = 16'h0020;
      step(4'b0011, 1'b0, 0);
      step(4'b0011, 1'b1, 1);
      step(4'b0011, 1'b1, 1);
      step(4'b0011, 1'b1, 1);
      step(4'b0011, 1'b1, 0);
      step(4'b0011, 1'b1, 1);
      step(4'b0011, 1'b1, 1);
      step(4'b0011, 1'b1, 1);
      step(4'b0000, 1'b1, -1);

      // lone requester, no bubble
      weight = 16'h0000;
      step(4'b0100, 1'b0, 2);
      for (int i = 0; i < 4; i++) step(4'b0100, 1'b1, 2);
      step(4'b0000, 1'b1, -1);

      // weight captured at issue, then abandon hands to client 3 with its own credit (0)
      weight = 16'h0300;
      step(4'b0100, 1'b0, 2);
      weight = 16'h0000;
      step(4'b0100, 1'b0, 2);
      step(4'b0100, 1'b1, 2);
      step(4'b1001, 1'b0, 3);
      step(4'b1001, 1'b1, 0);
      step(4'b0000, 1'b1, -1);

      // reset mid-tenure, then ptr restarts so client 1 beats client 2
      weight = 16'h0020;
      step(4'b0010, 1'b0, 1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1 check_now("reset_mid_tenure", -1);
      @(posedge clk); #1;
      rst = 1'b0;
      step(4'b0110, 1'b0, 1);
      step(4'b0000, 1'b1, -1);
      step(4'b0000, 1'b0, -1);

      @(negedge clk); #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
